riscv_retire_checker: RTL and testbench
=======================================

// Module: riscv_retire_checker
// PURPOSE
//   Synthesizable, self-checking monitor for the register-file writeback port of riscv_cpu.
//   Holds a programmable table of expected (rd, data) retirements and scores each real
//   writeback against it, in order. Keeps pass/fail counts, captures the first mismatch and
//   times out with a watchdog. Used in simulation and on FPGA bring-up.
// PARAMETERS
//   XLEN           32    data width of writeback and expected values
//   NUM_CHECKS     16    depth of expected-result table (>=1)
//   TIMEOUT_CYCLES 1024  max cycles between accepted writebacks before timeout (>=2)
//   IDX_W          $clog2(NUM_CHECKS+1)  derived; index/count width
// PORTS
//   clk            in   1      clock, all state on rising edge
//   rst            in   1      asynchronous, active-high reset
//   exp_wr_en      in   1      write one table entry (accepted only when not RUN)
//   exp_wr_idx     in   IDX_W  entry index; writes with idx>=NUM_CHECKS are dropped
//   exp_rd         in   5      expected destination register
//   exp_data       in   XLEN   expected writeback value
//   num_checks     in   IDX_W  active entries, sampled on start; clamped to NUM_CHECKS
//   start          in   1      single-cycle pulse: clear scores, enter RUN
//   wb_valid       in   1      writeback retiring this cycle (mem_wb.valid & rf_wr_en)
//   wb_rd          in   5      writeback destination register
//   wb_data        in   XLEN   writeback value
//   busy           out  1      FSM in RUN
//   done           out  1      FSM in DONE (level, held until next start)
//   timeout        out  1      run ended by watchdog (valid when done)
//   pass_count     out  IDX_W  matched retirements
//   fail_count     out  IDX_W  mismatched + unretired entries
//   first_fail_idx out  IDX_W  table index of first failure; all-ones if none
//   first_fail_data out XLEN   wb_data seen at first failure (0 if timeout-caused)
// BEHAVIOUR
//   - Reset: FSM=IDLE. busy, done, timeout, pass_count, fail_count, first_fail_data = 0.
//     first_fail_idx = all-ones. Table contents are not reset (undefined until written).
//   - FSM states:
//     IDLE: start moves to RUN. If num_checks == 0 after clamp, start moves to DONE with
//       zero counts.
//     RUN: compares writebacks against the table; leaves on all checks scored or on timeout.
//     DONE: start restarts the run (same as from IDLE).
//   - start in RUN is ignored.
//   - On start: ptr=0, counters cleared, first_fail_* reset, watchdog=0, num_checks latched.
//   - Table writes: take effect at the clock edge in IDLE or DONE; ignored in RUN.
//   - RUN, per cycle:
//     - Writebacks with wb_valid=1 and wb_rd != 0 are scored against entry[ptr].
//       Writebacks to x0 are ignored.
//     - Match requires wb_rd == exp_rd AND wb_data == exp_data; a match increments pass_count.
//     - A mismatch increments fail_count. On the first failure, also latch
//       first_fail_idx = ptr and first_fail_data = wb_data.
//     - Counter updates are visible 1 cycle after the scored edge; ptr advances by 1.
//     - Scoring the entry at ptr == latched_num-1 moves to DONE at the same edge, so done
//       rises 1 cycle after the last writeback.
//     - Writebacks after DONE are ignored.
//   - Watchdog:
//     - Counter increments each RUN cycle with no scored writeback and clears on a scored one.
//     - When it reaches TIMEOUT_CYCLES-1 with no scored writeback, go to DONE with timeout=1.
//     - Unscored entries (latched_num - ptr) are added to fail_count.
//     - If no failure was recorded yet: first_fail_idx = ptr, first_fail_data = 0.
//   - Simultaneous events: a scored writeback on the timeout cycle is scored and clears the
//     watchdog, so no timeout occurs. exp_wr_en together with start writes first; the
//     run uses the new entry.
//   - Counters cannot overflow: pass_count + fail_count <= latched num_checks.
//   - Reset mid-RUN: immediate return to IDLE, all outputs at reset values.
// TESTING
//   1 load {x4=0xF, x5=0x5, x6=0x0}, num_checks=3, start, drive 3 matching wb
//     -> pass=3 fail=0 done=1 timeout=0 first_fail_idx=all-ones.
//   2 same table; 2nd wb is x5=0x6
//     -> pass=2 fail=1 first_fail_idx=1 first_fail_data=0x6.
//   3 right data, wrong reg: wb x7=0xF against entry x4=0xF -> fail=1 first_fail_idx=0.
//   4 TIMEOUT_CYCLES=16, num_checks=3, only 1 matching wb, then idle
//     -> timeout=1 pass=1 fail=2 first_fail_idx=1, 16 cycles after that wb.
//   5 x0 writeback 0x1234 mid-run, and exp_wr_en during RUN
//     -> neither changes score nor table.
//   6 rst=1 mid-run after 1 pass -> all outputs zero/idle at once.
//     Restart from DONE -> counts cleared. num_checks=20 with NUM_CHECKS=16 -> 16 scored.

Source files
------------

// File: rtl/riscv_retire_checker_if.sv
// Purpose: bundles the expected-table write port, run control, writeback bus and score outputs.
// Latency: n/a (wiring only).
// Backpressure: none; master drives table/control/writeback, slave (checker) drives scores.
//   master: exp_wr_en/exp_wr_idx/exp_rd/exp_data, num_checks, start, wb_valid/wb_rd/wb_data
//   slave : busy, done, timeout, pass_count, fail_count, first_fail_idx, first_fail_data
interface riscv_retire_checker_if #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 5
);
    logic             exp_wr_en;
    logic [IDX_W-1:0] exp_wr_idx;
    logic [4:0]       exp_rd;
    logic [XLEN-1:0]  exp_data;
    logic [IDX_W-1:0] num_checks;
    logic             start;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [IDX_W-1:0] pass_count;
    logic [IDX_W-1:0] fail_count;
    logic [IDX_W-1:0] first_fail_idx;
    logic [XLEN-1:0]  first_fail_data;

    modport master (
        output exp_wr_en, exp_wr_idx, exp_rd, exp_data, num_checks, start,
        output wb_valid, wb_rd, wb_data,
        input  busy, done, timeout, pass_count, fail_count, first_fail_idx, first_fail_data
    );

    modport slave (
        input  exp_wr_en, exp_wr_idx, exp_rd, exp_data, num_checks, start,
        input  wb_valid, wb_rd, wb_data,
        output busy, done, timeout, pass_count, fail_count, first_fail_idx, first_fail_data
    );
endinterface

// File: rtl/riscv_retire_checker.sv
// Purpose: scores register-file writebacks in order against a programmable (rd, data) table.
// Latency: score/counter updates visible 1 cycle after the scored edge; done rises 1 cycle after the last writeback.
// Backpressure: none; every writeback is observed, writebacks to x0 and outside RUN are ignored.
//   Ports: clk, rst (async active-high) plus bus (slave modport): table write port, num_checks/start
//   control, wb_valid/wb_rd/wb_data writeback, busy/done/timeout status, pass/fail counts, first-failure capture.
module riscv_retire_checker #(
    parameter int XLEN           = 32,
    parameter int NUM_CHECKS     = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int IDX_W          = $clog2(NUM_CHECKS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    riscv_retire_checker_if.slave bus
);

    localparam int TBL_AW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES);

    localparam logic [IDX_W-1:0] NUM_MAX  = IDX_W'(NUM_CHECKS);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] num_q, num_d;
    logic [IDX_W-1:0] pass_q, pass_d;
    logic [IDX_W-1:0] fail_q, fail_d;
    logic [IDX_W-1:0] ffi_q, ffi_d;
    logic [XLEN-1:0]  ffd_q, ffd_d;
    logic             timeout_q, timeout_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;

    // Expected-result table; contents are only meaningful once written.
    logic [4:0]       tbl_rd   [NUM_CHECKS];
    logic [XLEN-1:0]  tbl_data [NUM_CHECKS];

    logic             tbl_we;
    logic [TBL_AW-1:0] tbl_widx;
    logic [TBL_AW-1:0] tbl_ridx;
    logic [IDX_W-1:0] num_clamped;
    logic             scored;
    logic             hit;

    always_comb begin
        tbl_we   = bus.exp_wr_en && (state_q != S_RUN) && (bus.exp_wr_idx < NUM_MAX);
        tbl_widx = bus.exp_wr_idx[TBL_AW-1:0];
        // ptr never reaches NUM_CHECKS while in RUN, so the truncated index is exact.
        tbl_ridx = ptr_q[TBL_AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_rd[tbl_widx]   <= bus.exp_rd;
            tbl_data[tbl_widx] <= bus.exp_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        num_d       = num_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        ffi_d       = ffi_q;
        ffd_d       = ffd_q;
        timeout_d   = timeout_q;
        wdog_d      = wdog_q;

        num_clamped = (bus.num_checks > NUM_MAX) ? NUM_MAX : bus.num_checks;
        scored      = (state_q == S_RUN) && bus.wb_valid && (bus.wb_rd != 5'd0);
        hit         = (bus.wb_rd == tbl_rd[tbl_ridx]) && (bus.wb_data == tbl_data[tbl_ridx]);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    ptr_d     = '0;
                    pass_d    = '0;
                    fail_d    = '0;
                    ffi_d     = '1;
                    ffd_d     = '0;
                    timeout_d = 1'b0;
                    wdog_d    = '0;
                    num_d     = num_clamped;
                    // An empty table has nothing to wait for.
                    state_d   = (num_clamped == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (scored) begin
                    // A scored writeback always wins over the watchdog on the same edge.
                    wdog_d = '0;
                    ptr_d  = ptr_q + IDX_ONE;
                    if (hit) begin
                        pass_d = pass_q + IDX_ONE;
                    end else begin
                        fail_d = fail_q + IDX_ONE;
                        if (fail_q == '0) begin
                            ffi_d = ptr_q;
                            ffd_d = bus.wb_data;
                        end
                    end
                    if (ptr_q == num_q - IDX_ONE) begin
                        state_d = S_DONE;
                    end
                end else if (wdog_q == WD_LAST) begin
                    // Every entry not yet retired counts as a failure.
                    timeout_d = 1'b1;
                    fail_d    = fail_q + (num_q - ptr_q);
                    if (fail_q == '0) begin
                        ffi_d = ptr_q;
                        ffd_d = '0;
                    end
                    state_d   = S_DONE;
                end else begin
                    wdog_d = wdog_q + WD_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            num_q     <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
            ffi_q     <= '1;
            ffd_q     <= '0;
            timeout_q <= 1'b0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            num_q     <= num_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            ffi_q     <= ffi_d;
            ffd_q     <= ffd_d;
            timeout_q <= timeout_d;
            wdog_q    <= wdog_d;
        end
    end

    assign bus.busy            = (state_q == S_RUN);
    assign bus.done            = (state_q == S_DONE);
    assign bus.timeout         = timeout_q;
    assign bus.pass_count      = pass_q;
    assign bus.fail_count      = fail_q;
    assign bus.first_fail_idx  = ffi_q;
    assign bus.first_fail_data = ffd_q;

endmodule

// File: tb/tb_riscv_retire_checker.sv
// Purpose: randomized + directed stimulus for riscv_retire_checker, scored by a sequence-level model.
// Latency: expected done cycle is derived from the model and checked when done rises.
// Backpressure: none; the monitor pops one expected result per rising edge of done.
module tb_riscv_retire_checker;
    localparam int XLEN = 32;
    localparam int NC   = 16;
    localparam int TO   = 16;
    localparam int IW   = $clog2(NC + 1);
    localparam int ALL1 = (1 << IW) - 1;

    typedef struct {
        int          pass_n;
        int          fail_n;
        int          ffi;
        logic [31:0] ffd;
        bit          to;
        int          done_cyc;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   run_id = 0;
    exp_t sb[$];

    logic [4:0]      m_rd   [NC];
    logic [XLEN-1:0] m_data [NC];

    bit              s_v[$];
    logic [4:0]      s_rd[$];
    logic [XLEN-1:0] s_d[$];
    bit              s_st[$];
    bit              s_we[$];
    logic [IW-1:0]   s_wi[$];
    logic [4:0]      s_wr[$];
    logic [XLEN-1:0] s_wd[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    riscv_retire_checker_if #(.XLEN(XLEN), .IDX_W(IW)) bus();

    riscv_retire_checker #(
        .XLEN(XLEN), .NUM_CHECKS(NC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.exp_wr_en  = 1'b0;
        bus.exp_wr_idx = '0;
        bus.exp_rd     = '0;
        bus.exp_data   = '0;
        bus.num_checks = '0;
        bus.start      = 1'b0;
        bus.wb_valid   = 1'b0;
        bus.wb_rd      = '0;
        bus.wb_data    = '0;
    endtask

    task automatic wr_entry(input int idx, input logic [4:0] rd, input logic [XLEN-1:0] d);
        @(negedge clk);
        drive_idle();
        bus.exp_wr_en  = 1'b1;
        bus.exp_wr_idx = IW'(idx);
        bus.exp_rd     = rd;
        bus.exp_data   = d;
        if (idx < NC) begin
            m_rd[idx]   = rd;
            m_data[idx] = d;
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic clear_seq();
        s_v.delete(); s_rd.delete(); s_d.delete(); s_st.delete();
        s_we.delete(); s_wi.delete(); s_wr.delete(); s_wd.delete();
    endtask

    task automatic push_cyc(input bit v, input logic [4:0] rd, input logic [XLEN-1:0] d, input bit st,
                            input bit we, input logic [IW-1:0] wi, input logic [4:0] wr, input logic [XLEN-1:0] wd);
        s_v.push_back(v); s_rd.push_back(rd); s_d.push_back(d); s_st.push_back(st);
        s_we.push_back(we); s_wi.push_back(wi); s_wr.push_back(wr); s_wd.push_back(wd);
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic [XLEN-1:0] d);
        push_cyc(1'b1, rd, d, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push_cyc(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Random cycle that must not be scored: either invalid, or a write to x0.
    task automatic push_noise();
        bit v;
        v = 1'($urandom_range(0, 1));
        push_cyc(v, v ? 5'd0 : 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0,
                 IW'($urandom_range(0, ALL1)), 5'($urandom_range(0, 31)), $urandom);
    endtask

    // Walks the per-cycle sequence: scored writebacks consume table entries in order;
    // TO consecutive unscored cycles end the run with the rest counted as failures.
    task automatic model_run(input int num, output exp_t e);
        int n, ptr, gap, fin;
        n = (num > NC) ? NC : num;
        e.pass_n = 0; e.fail_n = 0; e.ffi = ALL1; e.ffd = '0; e.to = 1'b0; e.id = run_id;
        ptr = 0; gap = 0;
        fin = (n == 0) ? 0 : -1;
        for (int k = 0; k < s_v.size() && fin < 0; k++) begin
            if (s_v[k] && s_rd[k] != 5'd0) begin
                gap = 0;
                if (s_rd[k] == m_rd[ptr] && s_d[k] == m_data[ptr]) begin
                    e.pass_n++;
                end else begin
                    if (e.fail_n == 0) begin
                        e.ffi = ptr;
                        e.ffd = s_d[k];
                    end
                    e.fail_n++;
                end
                ptr++;
                if (ptr == n) fin = k + 1;
            end else begin
                gap++;
                if (gap == TO) begin
                    e.to = 1'b1;
                    if (e.fail_n == 0) begin
                        e.ffi = ptr;
                        e.ffd = '0;
                    end
                    e.fail_n += n - ptr;
                    fin = k + 1;
                end
            end
        end
        e.done_cyc = fin;
    endtask

    task automatic run_seq(input int num, input bit ws, input int wi, input logic [4:0] wr, input logic [XLEN-1:0] wd);
        exp_t e;
        int   s, fin;
        push_idle(TO + 1);
        run_id++;
        if (ws && wi < NC) begin
            m_rd[wi]   = wr;
            m_data[wi] = wd;
        end
        model_run(num, e);
        fin = e.done_cyc;
        @(negedge clk);
        s = cyc + 1;
        e.done_cyc = s + fin;
        sb.push_back(e);
        drive_idle();
        bus.start      = 1'b1;
        bus.num_checks = IW'(num);
        bus.exp_wr_en  = ws;
        bus.exp_wr_idx = IW'(wi);
        bus.exp_rd     = wr;
        bus.exp_data   = wd;
        for (int k = 0; k < s_v.size(); k++) begin
            @(negedge clk);
            bus.wb_valid   = s_v[k];
            bus.wb_rd      = s_rd[k];
            bus.wb_data    = s_d[k];
            bus.num_checks = IW'($urandom_range(0, ALL1));
            bus.start      = s_st[k] && (k < fin);
            bus.exp_wr_en  = s_we[k] && (k < fin);
            bus.exp_wr_idx = s_wi[k];
            bus.exp_rd     = s_wr[k];
            bus.exp_data   = s_wd[k];
        end
        @(negedge clk);
        drive_idle();
        for (int w = 0; w < 4 && sb.size() != 0; w++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL run%0d_done_missing: done not seen, expected at cycle %0d", run_id, e.done_cyc);
            sb.delete();
        end
        clear_seq();
    endtask

    task automatic gen_random(input int num);
        int n, g, gap;
        logic [4:0]      rd;
        logic [XLEN-1:0] d;
        n = (num > NC) ? NC : num;
        g = 0;
        clear_seq();
        while (g < n + 2) begin
            gap = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 2);
            for (int i = 0; i < gap; i++) push_noise();
            if (g < NC) begin
                rd = m_rd[g];
                d  = m_data[g];
            end else begin
                rd = 5'($urandom_range(1, 31));
                d  = $urandom;
            end
            case ($urandom_range(0, 9))
                0:       rd = 5'($urandom_range(1, 31));
                1:       d  = d ^ (32'h1 << $urandom_range(0, 31));
                default: ;
            endcase
            if (rd == 5'd0) rd = 5'd1;
            push_cyc(1'b1, rd, d, $urandom_range(0, 15) == 0, 1'b0, '0, '0, '0);
            g++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},    64'(bus.busy), 64'd0);
        chk({tag, "_done"},    64'(bus.done), 64'd0);
        chk({tag, "_timeout"}, 64'(bus.timeout), 64'd0);
        chk({tag, "_pass"},    64'(bus.pass_count), 64'd0);
        chk({tag, "_fail"},    64'(bus.fail_count), 64'd0);
        chk({tag, "_ffi"},     64'(bus.first_fail_idx), 64'(ALL1));
        chk({tag, "_ffd"},     64'(bus.first_fail_data), 64'd0);
    endtask

    // Monitor: each rising edge of done is one finished run; compare with the oldest expectation.
    initial begin
        exp_t e;
        logic dprev;
        dprev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                dprev = 1'b0;
            end else begin
                if (bus.done === 1'b1 && dprev !== 1'b1) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_done: done rose at cycle %0d with no run pending", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("run%0d_done_cycle", e.id), 64'(cyc), 64'(e.done_cyc));
                        chk($sformatf("run%0d_pass", e.id), 64'(bus.pass_count), 64'(e.pass_n));
                        chk($sformatf("run%0d_fail", e.id), 64'(bus.fail_count), 64'(e.fail_n));
                        chk($sformatf("run%0d_timeout", e.id), 64'(bus.timeout), 64'(e.to));
                        chk($sformatf("run%0d_ffi", e.id), 64'(bus.first_fail_idx), 64'(e.ffi));
                        chk($sformatf("run%0d_ffd", e.id), 64'(bus.first_fail_data), 64'(e.ffd));
                        chk($sformatf("run%0d_busy", e.id), 64'(bus.busy), 64'd0);
                    end
                end
                dprev = bus.done;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int num;
        drive_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < NC; i++) wr_entry(i, 5'(i + 1), $urandom);
        wr_entry(0, 5'd4, 32'hF);
        wr_entry(1, 5'd5, 32'h5);
        wr_entry(2, 5'd6, 32'h0);
        wr_entry(16, 5'd9, 32'hDEAD_BEEF);
        wr_entry(18, 5'd9, 32'hDEAD_BEEF);

        // All match.
        push_wb(5'd4, 32'hF); push_wb(5'd5, 32'h5); push_wb(5'd6, 32'h0);
        run_seq(3, 1'b0, 0, '0, '0);
        // Wrong data on the second entry.
        push_wb(5'd4, 32'hF); push_wb(5'd5, 32'h6); push_wb(5'd6, 32'h0);
        run_seq(3, 1'b0, 0, '0, '0);
        // Right data, wrong register.
        push_wb(5'd7, 32'hF); push_wb(5'd5, 32'h5); push_wb(5'd6, 32'h0);
        run_seq(3, 1'b0, 0, '0, '0);
        // x0 writeback, table write and start during RUN are all ignored.
        push_wb(5'd4, 32'hF);
        push_cyc(1'b1, 5'd0, 32'h1234, 1'b0, 1'b0, '0, '0, '0);
        push_cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, IW'(1), 5'd5, 32'h99);
        push_cyc(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, '0, '0, '0);
        push_wb(5'd5, 32'h5); push_wb(5'd6, 32'h0);
        run_seq(3, 1'b0, 0, '0, '0);
        push_wb(5'd4, 32'hF); push_wb(5'd5, 32'h5); push_wb(5'd6, 32'h0);
        run_seq(3, 1'b0, 0, '0, '0);
        // Watchdog: one pass then silence.
        push_wb(5'd4, 32'hF);
        run_seq(3, 1'b0, 0, '0, '0);
        // Gap one short of the watchdog limit does not time out.
        push_wb(5'd4, 32'hF); push_idle(TO - 1); push_wb(5'd5, 32'h5); push_wb(5'd6, 32'h0);
        run_seq(3, 1'b0, 0, '0, '0);
        // Table write together with start is used by that run.
        push_wb(5'd10, 32'hCAFE); push_wb(5'd5, 32'h5); push_wb(5'd6, 32'h0);
        run_seq(3, 1'b1, 0, 5'd10, 32'hCAFE);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        drive_idle();
        bus.start = 1'b1;
        bus.num_checks = IW'(3);
        @(negedge clk);
        drive_idle();
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd10; bus.wb_data = 32'hCAFE;
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        chk("midrun_busy", 64'(bus.busy), 64'd1);
        chk("midrun_pass", 64'(bus.pass_count), 64'd1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clk);
        rst = 1'b0;

        // Empty table from IDLE goes straight to DONE.
        clear_seq();
        run_seq(0, 1'b0, 0, '0, '0);
        // num_checks beyond the table depth is clamped.
        for (int i = 0; i < NC; i++) push_wb(m_rd[i], m_data[i]);
        run_seq(20, 1'b0, 0, '0, '0);

        for (int r = 0; r < 25; r++) begin
            repeat ($urandom_range(0, 3)) wr_entry($urandom_range(0, NC - 1), 5'($urandom_range(1, 31)), $urandom);
            if ($urandom_range(0, 3) == 0) wr_entry($urandom_range(NC, ALL1), 5'($urandom_range(0, 31)), $urandom);
            num = ($urandom_range(0, 5) == 0) ? $urandom_range(NC + 1, ALL1) : $urandom_range(1, NC);
            gen_random(num);
            if ($urandom_range(0, 3) == 0)
                run_seq(num, 1'b1, $urandom_range(0, ALL1), 5'($urandom_range(1, 31)), $urandom);
            else
                run_seq(num, 1'b0, 0, '0, '0);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
